perf_counter_dumper: RTL

- Performance-event accumulator and snapshot serializer; the source stage for the simulation logging/perf-report path.
- Counts single-bit event pulses from core units into saturating counters. Runs a free-running 64-bit cycle counter that is used as the log timestamp.
- Periodically, or on request, snapshots all counters and streams them out one per handshake to the log/difftest event sink.

---
 rtl/perf_counter_dumper.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/perf_counter_dumper.sv
// Perf-event accumulator with saturating counters, a 64-bit cycle timestamp and a snapshot streamer.
// Define PERF_DUMP_SKIP_ZERO_EN to stream only nonzero snapshot entries.
module perf_counter_dumper #(
  parameter int NUM_EVENTS    = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int DUMP_INTERVAL = 10000,
  parameter int IDX_WIDTH     = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] ev_i,
  input  logic                  dump_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [CNT_WIDTH-1:0]  out_value,
  output logic [63:0]           out_cycle,
  output logic                  busy,
  output logic [63:0]           cycle_cnt
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_EVENTS - 1);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] live   [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] shadow [NUM_EVENTS];
  logic [IDX_WIDTH-1:0] idx, idx_n;
  logic                 pending, pending_n;
  logic                 periodic, trigger, snap, fire;
  logic [IDX_WIDTH-1:0] cur_idx;
  logic                 cur_found, more;

  generate
    if (DUMP_INTERVAL != 0) begin : g_interval
      logic [31:0] int_cnt;
      assign periodic = (int_cnt == 32'(DUMP_INTERVAL - 1));
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          int_cnt <= '0;
        else if (periodic) int_cnt <= '0;
        else               int_cnt <= int_cnt + 32'd1;
      end
    end else begin : g_no_interval
      assign periodic = 1'b0;
    end
  endgenerate

  // cur_idx is the entry presented now; more says another entry follows it.
`ifdef PERF_DUMP_SKIP_ZERO_EN
  always_comb begin
    cur_found = 1'b0;
    cur_idx   = idx;
    more      = 1'b0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (IDX_WIDTH'(i) >= idx && shadow[i] != '0) begin
        cur_found = 1'b1;
        cur_idx   = IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (IDX_WIDTH'(i) > cur_idx && shadow[i] != '0) more = 1'b1;
    end
  end
`else
  assign cur_found = 1'b1;
  assign cur_idx   = idx;
  assign more      = (idx != LAST_IDX);
`endif

  // Stream handshake: an entry transfers on a rising clk edge where out_valid and
  // out_ready are both high; out_valid and the payload hold until that edge.
  assign trigger   = dump_req | periodic;
  assign snap      = (state == IDLE) && (trigger || pending);
  assign out_valid = (state == DUMP) && cur_found;
  assign fire      = out_valid && out_ready;
  assign busy      = (state == DUMP);
  assign out_idx   = cur_idx;
  assign out_value = shadow[cur_idx];

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    case (state)
      IDLE: begin
        if (snap) begin
          state_n   = DUMP;
          idx_n     = '0;
          pending_n = 1'b0;
        end
      end
      DUMP: begin
        if (trigger) pending_n = 1'b1;
        if (!cur_found) begin
          state_n = IDLE;
        end else if (fire) begin
          if (more) idx_n = cur_idx + IDX_WIDTH'(1);
          else      state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      cycle_cnt <= '0;
      out_cycle <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pending   <= pending_n;
      cycle_cnt <= cycle_cnt + 64'd1;
      if (snap) out_cycle <= cycle_cnt;
    end
  end

  // The snapshot cycle's own event seeds the new window instead of the shadow copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (snap) begin
          shadow[i] <= live[i];
          live[i]   <= CNT_WIDTH'(ev_i[i]);
        end else if (ev_i[i] && live[i] != '1) begin
          live[i] <= live[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
